// File: rtl/udp_echo_responder.sv
// UDP echo service: buffers one datagram addressed to PORT and, once the stack
// commits it, sends the same payload back to the sender with the ports swapped.
module udp_echo_responder #(
  parameter int PORT      = 7,
  parameter int BUF_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_start,
  input  logic [31:0] rx_src_ip,
  input  logic [15:0] rx_src_port,
  input  logic [15:0] rx_dst_port,
  input  logic [15:0] rx_payload_len,
  input  logic        rx_data_valid,
  input  logic [2:0]  rx_bytes_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [31:0] tx_dst_ip,
  output logic [15:0] tx_src_port,
  output logic [15:0] tx_dst_port,
  output logic [15:0] tx_payload_len,
  output logic        tx_data_valid,
  output logic [2:0]  tx_bytes_valid,
  output logic [31:0] tx_data,
  output logic        tx_commit,
  output logic [31:0] echo_count,
  output logic [31:0] drop_count
);

  localparam int AW  = $clog2(BUF_WORDS + 1);
  localparam int RAW = $clog2(BUF_WORDS);
  localparam logic [AW-1:0] PTR_END = AW'(BUF_WORDS);
  localparam logic [16:0]   MAX_LEN = 17'(4 * BUF_WORDS);
  localparam logic [15:0]   PORT_W  = 16'(PORT);

  typedef enum logic [1:0] {IDLE, RX, WAIT_READY, TX} state_t;

  // Byte counter saturates so a runaway sender can never wrap it back into a match.
  function automatic logic [16:0] sat_add(input logic [16:0] a, input logic [2:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[17] ? '1 : s[16:0];
  endfunction

  logic [31:0] mem [BUF_WORDS];

  state_t        state;
  logic [31:0]   lat_ip;
  logic [15:0]   lat_port;
  logic [15:0]   lat_len;
  logic [AW-1:0] wr_ptr;
  logic [16:0]   byte_cnt;
  logic [14:0]   tx_idx;

  logic          hdr_to_port;
  logic          hdr_fits;
  logic          accept;
  logic [16:0]   byte_next;
  logic          wr_en;
  logic [14:0]   n_words;
  logic [2:0]    last_bv;
  logic [1:0]    drop_inc;

  assign hdr_to_port = rx_start && (rx_dst_port == PORT_W);
  assign hdr_fits    = ({1'b0, rx_payload_len} <= MAX_LEN);
  assign accept      = hdr_to_port && hdr_fits;
  assign byte_next   = rx_data_valid ? sat_add(byte_cnt, rx_bytes_valid) : byte_cnt;
  assign wr_en       = (state == RX) && !rx_start && !rx_drop && rx_data_valid &&
                       (wr_ptr != PTR_END);
  assign n_words     = {1'b0, lat_len[15:2]} + {14'b0, |lat_len[1:0]};
  assign last_bv     = (lat_len[1:0] == 2'b00) ? 3'd4 : {1'b0, lat_len[1:0]};

  // A restart in RX can cost two drops at once: the abandoned datagram plus an oversize header.
  always_comb begin
    drop_inc = 2'd0;
    unique case (state)
      IDLE:       if (hdr_to_port && !hdr_fits) drop_inc = 2'd1;
      RX: begin
        if (rx_start)
          drop_inc = (hdr_to_port && !hdr_fits) ? 2'd2 : 2'd1;
        else if (rx_drop)
          drop_inc = 2'd1;
        else if (rx_commit && (byte_next != {1'b0, lat_len}))
          drop_inc = 2'd1;
      end
      WAIT_READY,
      TX:         if (hdr_to_port) drop_inc = 2'd1;
      default:    drop_inc = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[RAW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_ip         <= '0;
      lat_port       <= '0;
      lat_len        <= '0;
      wr_ptr         <= '0;
      byte_cnt       <= '0;
      tx_idx         <= '0;
      tx_start       <= 1'b0;
      tx_dst_ip      <= '0;
      tx_src_port    <= '0;
      tx_dst_port    <= '0;
      tx_payload_len <= '0;
      tx_data_valid  <= 1'b0;
      tx_bytes_valid <= '0;
      tx_data        <= '0;
      tx_commit      <= 1'b0;
      echo_count     <= '0;
      drop_count     <= '0;
    end else begin
      tx_start      <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_commit     <= 1'b0;
      drop_count    <= drop_count + {30'b0, drop_inc};

      unique case (state)
        IDLE, RX: begin
          if (rx_start) begin
            if (accept) begin
              state    <= RX;
              lat_ip   <= rx_src_ip;
              lat_port <= rx_src_port;
              lat_len  <= rx_payload_len;
              wr_ptr   <= '0;
              byte_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (state == RX) begin
            if (rx_drop) begin
              state <= IDLE;
            end else begin
              if (rx_data_valid) begin
                byte_cnt <= byte_next;
                if (wr_ptr != PTR_END) wr_ptr <= wr_ptr + AW'(1);
              end
              if (rx_commit)
                state <= (byte_next == {1'b0, lat_len}) ? WAIT_READY : IDLE;
            end
          end
        end

        WAIT_READY: begin
          if (tx_ready) begin
            state          <= TX;
            tx_start       <= 1'b1;
            tx_dst_ip      <= lat_ip;
            tx_src_port    <= PORT_W;
            tx_dst_port    <= lat_port;
            tx_payload_len <= lat_len;
            tx_idx         <= '0;
          end
        end

        // Synchronous RAM read lands directly in the tx_data output register.
        TX: begin
          if (tx_idx == n_words) begin
            tx_commit  <= 1'b1;
            echo_count <= echo_count + 32'd1;
            state      <= IDLE;
          end else begin
            tx_data_valid  <= 1'b1;
            tx_data        <= mem[tx_idx[RAW-1:0]];
            tx_bytes_valid <= (tx_idx == n_words - 15'd1) ? last_bv : 3'd4;
            tx_idx         <= tx_idx + 15'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
